regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file with an integrated pending-write scoreboard for the RVX10P pipeline. It writes on the rising clock edge and supplies an optional same-cycle write-to-read bypass. A per-register pending bit lets the ID stage detect RAW hazards against in-flight destinations without a separate hazard table. It replaces the fixed 2R1W negedge-write register file in the decode stage.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, register count; power of two, ≥ 2
- NRD, 2, number of read ports, 1..4
- AW, $clog2(NREGS), address width (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ra  in  NRD×AW  read addresses, one per port
- rd  out  NRD×XLEN  read data, combinational from ra
- rbusy  out  NRD  pending bit of ra[i], combinational
- we  in  1  write enable (WB stage)
- wa  in  AW  write address
- wd  in  XLEN  write data
- iss  in  1  issue strobe: mark iss_a as pending
- iss_a  in  AW  destination of the issuing instruction
- flush  in  1  clear all pending bits (pipeline flush)

Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.

## Operation
- Storage: NREGS×XLEN flops. Register 0 is hardwired to zero. Writes to address 0 are dropped. rd for ra=0 is always 0.
- Write: on posedge clk, if we and wa≠0, rf[wa] ← wd.
- Pending bits pend[NREGS-1:0]. On posedge, in priority order:
  - flush: clear every bit. iss is ignored that cycle, so nothing issues.
  - Otherwise, if we and wa≠0: clear pend[wa].
  - Otherwise, if iss and iss_a≠0: set pend[iss_a]. A set takes priority over a clear at the same address, because the younger instruction owns the register.
- pend[0] is never set.
- rbusy[i] = pend[ra[i]]. When bypass is enabled, rbusy[i] is also forced to 0 if we and wa=ra[i]≠0 this cycle, because the data is being delivered now.
- Each read port is independent. Any number of ports may read the same address.

## Timing
- Reset (async assert, sync-safe deassert by the upstream synchroniser): all rf entries become 0 and all pend bits become 0. rd and rbusy therefore read 0 during reset.
- Reset asserted mid-operation discards any write or issue in that cycle.
- Write latency: data written at edge N is visible on rd from just after edge N without bypass. With bypass, it is visible in the same cycle before edge N.
- Issue latency: iss at edge N shows up as rbusy from just after edge N.
- Simultaneous iss and we to the same nonzero address: the rf is updated and pend stays 1.
- Simultaneous flush and we: the write completes and all pend bits end at 0.
- There is no handshake. we and iss are single-cycle strobes sampled every edge.

## Configuration
- Macro RVX_RF_BYPASS_EN.
- Defined: rd[i] = wd when we and wa=ra[i]≠0; otherwise rd[i] = rf[ra[i]]. rbusy is masked as described in Operation.
- Undefined: rd[i] always reads rf. A same-cycle write becomes visible next cycle, and the pipeline must stall one cycle or forward externally.

## Structure
- Package rvx_rf_pkg holds:
  - the default XLEN/NREGS constants
  - typedef rf_addr_t and rf_word_t
  - localparam ZERO_REG = 0
- Sub-module rf_scoreboard contains the pend vector, the flush/set/clear priority logic, and the NRD rbusy lookups. It is instantiated once.
- regfile_mp keeps the storage array, the read muxes and the bypass.

## Test plan
- Reset check: pulse rst_n low mid-run, with NRD=3 and ra={1,2,31} -> rd all 0 and rbusy all 0 while rst_n=0 and after release.
- Write/read: we, wa=5, wd=0xDEADBEEF at edge N; ra[0]=5 -> 0xDEADBEEF after edge N. A write to wa=0 leaves rd for ra=0 at 0.
- Bypass: same-cycle we, wa=7, wd=0x12345678 with ra[1]=7:
  - With RVX_RF_BYPASS_EN: rd[1]=0x12345678 and rbusy[1]=0 before the edge.
  - Without it: the old value before the edge, the new value after.
- Scoreboard: iss with iss_a=9 -> rbusy=1 for ra=9. After a later we with wa=9 -> rbusy=0.
- Collision: iss with iss_a=4 and we with wa=4, wd=0xA5 in the same cycle -> rf[4]=0xA5 and pend[4]=1.
- Flush: pend {3,6,12} set, then flush together with iss_a=8 -> all rbusy 0, including port reads of 8.

Source files
------------

// File: rtl/rvx_rf_pkg.sv
// Shared constants and types for the RVX10P multi-port register file.
// Optional same-cycle write bypass is selected with the RVX_RF_BYPASS_EN macro.
package rvx_rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);
    localparam int unsigned ZERO_REG  = 0;

    typedef logic [XLEN_DEF-1:0] rf_word_t;
    typedef logic [AW_DEF-1:0]   rf_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits with flush/clear/set priority and per-port lookups.
module rf_scoreboard
    import rvx_rf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NRD-1:0][AW-1:0] i_ra,
    input  logic                   i_clr,
    input  logic [AW-1:0]          i_clr_a,
    input  logic                   i_set,
    input  logic [AW-1:0]          i_set_a,
    input  logic                   i_flush,
    output logic [NRD-1:0]         o_busy_c
);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;

    // The set is applied after the clear so a younger issue keeps ownership.
    always_comb begin
        w_pend_nxt = r_pend;
        if (i_flush) begin
            w_pend_nxt = '0;
        end else begin
            if (i_clr && (i_clr_a != AW'(ZERO_REG))) begin
                w_pend_nxt[i_clr_a] = 1'b0;
            end
            if (i_set && (i_set_a != AW'(ZERO_REG))) begin
                w_pend_nxt[i_set_a] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    always_comb begin
        o_busy_c = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            o_busy_c[i] = r_pend[i_ra[i]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// NRD-read / 1-write register file with pending-write scoreboard for the ID stage.
// Define RVX_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import rvx_rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD-1:0][AW-1:0]   ra,
    output logic [NRD-1:0][XLEN-1:0] rd,
    output logic [NRD-1:0]           rbusy,
    input  logic                     we,
    input  logic [AW-1:0]            wa,
    input  logic [XLEN-1:0]          wd,
    input  logic                     iss,
    input  logic [AW-1:0]            iss_a,
    input  logic                     flush
);

    logic [XLEN-1:0] r_rf [NREGS];
    logic [NRD-1:0]  w_pend;
    logic [NRD-1:0]  w_hit;

    // Entry 0 is reset to zero and never written, so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_rf[i] <= '0;
            end
        end else if (we && (wa != AW'(ZERO_REG))) begin
            r_rf[wa] <= wd;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_ra     (ra),
        .i_clr    (we),
        .i_clr_a  (wa),
        .i_set    (iss),
        .i_set_a  (iss_a),
        .i_flush  (flush),
        .o_busy_c (w_pend)
    );

    // A bypass hit delivers the data now, so the pending bit is masked too.
    always_comb begin
        w_hit = '0;
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < int'(NRD); i++) begin
`ifdef RVX_RF_BYPASS_EN
            w_hit[i] = rst_n && we && (wa == ra[i]) && (ra[i] != AW'(ZERO_REG));
`else
            w_hit[i] = 1'b0;
`endif
            rd[i]    = w_hit[i] ? wd : r_rf[ra[i]];
            rbusy[i] = w_pend[i] & ~w_hit[i];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized checks of regfile_mp (NRD=3) against an array-based reference model.
module tb_regfile_mp;
    import rvx_rf_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 3;
    localparam int unsigned AW    = 5;
`ifdef RVX_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic [NRD-1:0][AW-1:0]   ra;
    logic [NRD-1:0][XLEN-1:0] rd;
    logic [NRD-1:0]           rbusy;
    logic                     we;
    logic [AW-1:0]            wa;
    logic [XLEN-1:0]          wd;
    logic                     iss;
    logic [AW-1:0]            iss_a;
    logic                     flush;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ra    (ra),
        .rd    (rd),
        .rbusy (rbusy),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .iss   (iss),
        .iss_a (iss_a),
        .flush (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: register contents and pending set.
    rf_word_t         m_rf [NREGS];
    logic [NREGS-1:0] m_pend;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic model_reset();
        for (int i = 0; i < int'(NREGS); i++) m_rf[i] = '0;
        m_pend = '0;
    endtask

    task automatic model_edge();
        if (rst_n) begin
            if (we && wa != 0) m_rf[wa] = wd;
            if (flush) begin
                m_pend = '0;
            end else begin
                if (we && wa != 0) m_pend[wa] = 1'b0;
                if (iss && iss_a != 0) m_pend[iss_a] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < int'(NRD); i++) begin
            logic            hit;
            logic [XLEN-1:0] e_rd;
            logic            e_busy;
            hit    = BYP && rst_n && we && (wa == ra[i]) && (ra[i] != 0);
            e_rd   = hit ? wd : m_rf[ra[i]];
            e_busy = hit ? 1'b0 : m_pend[ra[i]];
            n_assert++;
            assert (rd[i] === e_rd) else begin
                n_fail++;
                $error("FAIL %s rd[%0d] ra=%0d observed=%h expected=%h", tag, i, ra[i], rd[i], e_rd);
            end
            n_assert++;
            assert (rbusy[i] === e_busy) else begin
                n_fail++;
                $error("FAIL %s rbusy[%0d] ra=%0d observed=%b expected=%b", tag, i, ra[i], rbusy[i], e_busy);
            end
        end
    endtask

    task automatic idle();
        we = 1'b0; iss = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        wa = '0; wd = '0; iss_a = '0;
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd31;
        model_reset();

        // Reset held and released
        #12;
        check_all("reset_low");
        rst_n = 1'b1;
        #1;
        check_all("reset_rel");
        tick();

        // Write then read back
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra[0] = 5'd5;
        #1; check_all("wr5_pre");
        tick(); idle();
        #1; chk("wr5_post", rd[0], 32'hDEADBEEF);
        check_all("wr5_post_all");

        // Writes to r0 are dropped
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra[0] = 5'd0;
        #1; chk("wr0_pre", rd[0], 32'h0);
        tick(); idle();
        #1; chk("wr0_post", rd[0], 32'h0);

        // Same-cycle write on port 1
        we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra[1] = 5'd7;
        #1; chk("byp_pre_rd", rd[1], BYP ? 32'h12345678 : 32'h0);
        chk("byp_pre_busy", XLEN'(rbusy[1]), 32'h0);
        tick(); idle();
        #1; chk("byp_post_rd", rd[1], 32'h12345678);

        // Issue marks pending, write-back clears it
        iss = 1'b1; iss_a = 5'd9; ra[2] = 5'd9;
        #1; check_all("iss9_pre");
        tick(); idle();
        #1; chk("iss9_busy", XLEN'(rbusy[2]), 32'h1);
        we = 1'b1; wa = 5'd9; wd = 32'h99;
        #1; chk("wb9_pre_busy", XLEN'(rbusy[2]), BYP ? 32'h0 : 32'h1);
        tick(); idle();
        #1; chk("wb9_post_busy", XLEN'(rbusy[2]), 32'h0);
        chk("wb9_post_rd", rd[2], 32'h99);

        // Issue and write-back to the same register
        iss = 1'b1; iss_a = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'hA5;
        tick(); idle();
        ra[0] = 5'd4;
        #1; chk("coll_rd", rd[0], 32'hA5);
        chk("coll_busy", XLEN'(rbusy[0]), 32'h1);

        // Flush beats a concurrent issue
        iss = 1'b1; iss_a = 5'd3; tick();
        iss_a = 5'd6; tick();
        iss_a = 5'd12; tick(); idle();
        ra[0] = 5'd3; ra[1] = 5'd6; ra[2] = 5'd12;
        #1; chk("pend_set", XLEN'(rbusy), 32'h7);
        flush = 1'b1; iss = 1'b1; iss_a = 5'd8;
        tick(); idle();
        #1; chk("flush_clr", XLEN'(rbusy), 32'h0);
        ra[0] = 5'd8; ra[1] = 5'd4;
        #1; chk("flush_iss8", XLEN'(rbusy), 32'h0);
        check_all("flush_all");

        // Reset pulsed mid-run while a write and an issue are presented
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd31;
        we = 1'b1; wa = 5'd2; wd = 32'hCAFEF00D; iss = 1'b1; iss_a = 5'd31;
        #1; rst_n = 1'b0; model_reset();
        #1; check_all("rst_mid_low");
        tick();
        check_all("rst_mid_edge");
        idle();
        #2; rst_n = 1'b1;
        #1; check_all("rst_mid_rel");
        ra[0] = 5'd5;
        #1; chk("rst_mid_r5", rd[0], 32'h0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < int'(NRD); i++) ra[i] = AW'($urandom_range(0, NREGS - 1));
            we    = 1'($urandom_range(0, 1));
            wa    = AW'($urandom_range(0, NREGS - 1));
            wd    = $urandom;
            iss   = 1'($urandom_range(0, 1));
            iss_a = AW'($urandom_range(0, NREGS - 1));
            flush = ($urandom_range(0, 15) == 0);
            if (n % 3 == 0) ra[1] = wa;
            if (n % 5 == 0) ra[2] = iss_a;
            #1; check_all("rand");
            tick();
        end
        idle();
        #1; check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
